// File: rtl/adder_pkg.sv
// Shared types and helpers for pipelined_adder: slice sizing, split legality check,
// per-stage control payload and the single-bit full-adder cell used by every slice.
package adder_pkg;

  // Sum and operand delay lines vary in width per instance, so only the fixed-width
  // control part of a stage payload lives here.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 1;
  endfunction

  function automatic bit legal_split(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Returns {carry_out, sum}
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// SLICE-bit ripple-carry adder built from full-adder cells; also exposes the carry
// into its MSB so the top level can derive signed overflow.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic       w_carry;
    logic [1:0] w_cell;
    w_carry  = cin;
    w_cell   = '0;
    s        = '0;
    c_msb_in = cin;
    for (int i = 0; i < SLICE; i++) begin
      c_msb_in = w_carry;
      w_cell   = full_add(a[i], b[i], w_carry);
      s[i]     = w_cell[0];
      w_carry  = w_cell[1];
    end
    cout = w_carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, carry chain split over STAGES register stages
// with valid/ready on both sides. Define ADDER_OVERFLOW_EN to add the Ovf output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Pin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Pout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (!legal_split(WIDTH, STAGES)) begin : g_badConfig
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_bEff;
  logic [WIDTH-1:0] w_aIn   [STAGES];
  logic [WIDTH-1:0] w_bIn   [STAGES];
  logic [WIDTH-1:0] w_sumIn [STAGES];
  logic             w_cIn   [STAGES];
  logic             w_vIn   [STAGES];
  logic             w_cout  [STAGES];
  logic [SLICE-1:0] w_s     [STAGES];
`ifdef ADDER_OVERFLOW_EN
  logic             w_cMsb  [STAGES];
`else
  logic             w_unusedCMsb [STAGES];
`endif

  stage_ctrl_t      r_ctrl [STAGES];
  logic [WIDTH-1:0] r_a    [STAGES];
  logic [WIDTH-1:0] r_b    [STAGES];
  logic [WIDTH-1:0] r_sum  [STAGES];

  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_ctrl[STAGES-1].valid;
  assign S         = r_sum[STAGES-1];
  assign Pout      = r_ctrl[STAGES-1].carry;
  assign w_bEff    = Sub ? ~B : B;

  // Each stage sees the full operand and partial-sum vectors of its predecessor and
  // works only on its own slice; unused upper/lower bits are trimmed by synthesis.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_aIn[k]   = A;
      assign w_bIn[k]   = w_bEff;
      assign w_sumIn[k] = '0;
      assign w_cIn[k]   = Pin;
      assign w_vIn[k]   = in_valid;
    end else begin : g_body
      assign w_aIn[k]   = r_a[k-1];
      assign w_bIn[k]   = r_b[k-1];
      assign w_sumIn[k] = r_sum[k-1];
      assign w_cIn[k]   = r_ctrl[k-1].carry;
      assign w_vIn[k]   = r_ctrl[k-1].valid;
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
      .a        (w_aIn[k][k*SLICE +: SLICE]),
      .b        (w_bIn[k][k*SLICE +: SLICE]),
      .cin      (w_cIn[k]),
      .s        (w_s[k]),
      .cout     (w_cout[k]),
`ifdef ADDER_OVERFLOW_EN
      .c_msb_in (w_cMsb[k])
`else
      .c_msb_in (w_unusedCMsb[k])
`endif
    );
  end

  // One global advance: the whole pipe shifts together or holds, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_sum[k]  <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k].valid <= w_vIn[k];
        r_ctrl[k].carry <= w_cout[k];
        r_a[k]          <= w_aIn[k];
        r_b[k]          <= w_bIn[k];
        r_sum[k]        <= w_sumIn[k];
        r_sum[k][k*SLICE +: SLICE] <= w_s[k];
      end
    end
  end

`ifdef ADDER_OVERFLOW_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_cMsb[STAGES-1] ^ w_cout[STAGES-1];
    end
  end

  assign Ovf = r_ovf;
`endif

endmodule
